// File: rtl/mem_mapper_multi.sv
// mem_mapper_multi: decodes one master bus onto NUM_SLAVES slave ports using
// the high address field addr[ADDR_WIDTH-1:SEL_LO]. Reads are pipelined up
// to MAX_OUTSTANDING deep. Only reads to the same slave are allowed in
// flight together, so responses come back in order without a reorder buffer.
// Unmapped reads are answered with zero data one cycle after acceptance.
// Optional feature macro: MEM_MAPPER_DECODE_ERROR_EN adds a sticky decode
// error flag with capture address and clear input.
module mem_mapper_multi #(
    parameter int NUM_SLAVES      = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int SEL_LO          = 28,
    parameter int SEL_BASE        = 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    output logic                                   ready,
    input  logic [ADDR_WIDTH-1:0]                  addr,
    input  logic [DATA_WIDTH-1:0]                  write_data,
    input  logic [DATA_WIDTH/8-1:0]                byte_enable,
    input  logic                                   write_req,
    input  logic                                   read_req,
    output logic [DATA_WIDTH-1:0]                  read_data,
    output logic                                   read_data_valid,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0]       s_addr,
    output logic [NUM_SLAVES*DATA_WIDTH-1:0]       s_write_data,
    output logic [NUM_SLAVES*(DATA_WIDTH/8)-1:0]   s_byte_enable,
    output logic [NUM_SLAVES-1:0]                  s_write_req,
    output logic [NUM_SLAVES-1:0]                  s_read_req,
    input  logic [NUM_SLAVES-1:0]                  s_ready,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]       s_read_data,
    input  logic [NUM_SLAVES-1:0]                  s_read_data_valid
`ifdef MEM_MAPPER_DECODE_ERROR_EN
    ,
    output logic                                   decode_error,
    output logic [ADDR_WIDTH-1:0]                  decode_error_addr,
    input  logic                                   decode_error_clear
`endif
);

    localparam int FW  = ADDR_WIDTH - SEL_LO;
    localparam int BW  = DATA_WIDTH / 8;
    localparam int IDW = $clog2(NUM_SLAVES + 1);
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [IDW-1:0] UNMAPPED = IDW'(NUM_SLAVES);

    logic [FW-1:0]         field;
    logic                  mapped;
    logic [IDW-1:0]        tgt;
    logic                  tgt_ready;
    logic                  rd_ok;
    logic                  rd_fire;
    logic                  rsp_hit;
    logic [DATA_WIDTH-1:0] rsp_data;

    logic [CW-1:0]         count_q, count_d;
    logic [IDW-1:0]        cur_id_q, cur_id_d;
    logic                  unm_pend_q, unm_pend_d;

    assign field = addr[ADDR_WIDTH-1:SEL_LO];

    // Address decode: target index and that target's accept signal.
    always_comb begin
        mapped    = 1'b0;
        tgt       = UNMAPPED;
        tgt_ready = 1'b1;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (int'(field) == SEL_BASE + i) begin
                mapped    = 1'b1;
                tgt       = IDW'(i);
                tgt_ready = s_ready[i];
            end
        end
    end

    // A new read may only join reads already in flight to the same target;
    // a same-cycle response does not free a slot early.
    assign rd_ok   = ((count_q == '0) || (tgt == cur_id_q)) && (count_q < CW'(MAX_OUTSTANDING));
    assign ready   = tgt_ready && (!read_req || rd_ok);
    assign rd_fire = read_req && rd_ok && tgt_ready;

    // Fan the master request out; only the decoded slave sees data and strobes.
    always_comb begin
        s_addr        = '0;
        s_write_data  = '0;
        s_byte_enable = '0;
        s_write_req   = '0;
        s_read_req    = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            s_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = addr;
            if (mapped && (tgt == IDW'(i))) begin
                s_write_data[i*DATA_WIDTH +: DATA_WIDTH] = write_data;
                s_byte_enable[i*BW +: BW]                = byte_enable;
                s_write_req[i]                           = write_req;
                s_read_req[i]                            = read_req && rd_ok;
            end
        end
    end

    // Route the response of the slave that owns the reads in flight.
    always_comb begin
        rsp_hit  = unm_pend_q;
        rsp_data = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (cur_id_q == IDW'(i)) begin
                rsp_hit  = s_read_data_valid[i];
                rsp_data = s_read_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign read_data_valid = (count_q != '0) && rsp_hit;
    assign read_data       = read_data_valid ? rsp_data : '0;

    // Next-state for the outstanding-read tracker.
    always_comb begin
        count_d    = count_q;
        cur_id_d   = cur_id_q;
        unm_pend_d = unm_pend_q;
        if (rd_fire && !read_data_valid) begin
            count_d = count_q + CW'(1);
        end else if (!rd_fire && read_data_valid) begin
            count_d = count_q - CW'(1);
        end
        if (rd_fire) begin
            cur_id_d   = tgt;
            unm_pend_d = !mapped;
        end else if (read_data_valid) begin
            unm_pend_d = 1'b0;
        end
    end

    // Outstanding-read tracker registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            cur_id_q   <= '0;
            unm_pend_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            cur_id_q   <= cur_id_d;
            unm_pend_q <= unm_pend_d;
        end
    end

`ifdef MEM_MAPPER_DECODE_ERROR_EN
    logic                  unm_acc;
    logic                  dec_err_q;
    logic [ADDR_WIDTH-1:0] dec_err_addr_q;

    assign unm_acc = !mapped && ready && (read_req || write_req);

    // Sticky error flag; the address of the first offending access is kept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_err_q      <= 1'b0;
            dec_err_addr_q <= '0;
        end else if (decode_error_clear) begin
            dec_err_q      <= 1'b0;
            dec_err_addr_q <= '0;
        end else if (unm_acc && !dec_err_q) begin
            dec_err_q      <= 1'b1;
            dec_err_addr_q <= addr;
        end
    end

    assign decode_error      = dec_err_q;
    assign decode_error_addr = dec_err_addr_q;
`endif

endmodule

// File: tb/tb_mem_mapper_multi.sv
// Testbench for mem_mapper_multi (default parameters). Slave models respond
// two cycles after an accepted read unless held; a scoreboard queue holds the
// expected read data for every accepted master read.
module tb_mem_mapper_multi;

    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ready;
    logic [31:0]   addr;
    logic [31:0]   write_data;
    logic [3:0]    byte_enable;
    logic          write_req;
    logic          read_req;
    logic [31:0]   read_data;
    logic          read_data_valid;
    logic [127:0]  s_addr;
    logic [127:0]  s_write_data;
    logic [15:0]   s_byte_enable;
    logic [3:0]    s_write_req;
    logic [3:0]    s_read_req;
    logic [3:0]    s_ready;
    logic [127:0]  s_read_data;
    logic [3:0]    s_read_data_valid;
`ifdef MEM_MAPPER_DECODE_ERROR_EN
    logic          decode_error;
    logic [31:0]   decode_error_addr;
    logic          decode_error_clear;
`endif

    mem_mapper_multi dut (
        .clk               (clk),
        .reset             (reset),
        .ready             (ready),
        .addr              (addr),
        .write_data        (write_data),
        .byte_enable       (byte_enable),
        .write_req         (write_req),
        .read_req          (read_req),
        .read_data         (read_data),
        .read_data_valid   (read_data_valid),
        .s_addr            (s_addr),
        .s_write_data      (s_write_data),
        .s_byte_enable     (s_byte_enable),
        .s_write_req       (s_write_req),
        .s_read_req        (s_read_req),
        .s_ready           (s_ready),
        .s_read_data       (s_read_data),
        .s_read_data_valid (s_read_data_valid)
`ifdef MEM_MAPPER_DECODE_ERROR_EN
        ,
        .decode_error      (decode_error),
        .decode_error_addr (decode_error_addr),
        .decode_error_clear(decode_error_clear)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          slv;
        logic [31:0] a;
        int          due;
    } sreq_t;

    typedef struct {
        logic [31:0] a;
        logic        wr;
        logic        rd;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [3:0]  sr;
        logic        e_ready;
        logic [3:0]  e_swr;
        logic [3:0]  e_srd;
        int          e_tgt;
    } vec_t;

    sreq_t       sq[$];
    logic [31:0] exp_q[$];
    logic [3:0]  hold;
    int          cyc;
    int          checks;
    int          errors;
    int          wr_acc[NS];
    vec_t        vecs[10];

    function automatic logic [31:0] resp_fn(input logic [31:0] a);
        return 32'hDEAD_BEEF ^ a ^ 32'h1000_0004;
    endfunction

    function automatic bit is_mapped(input logic [31:0] a);
        return (a[31:28] >= 4'd1) && (a[31:28] <= 4'd4);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor current cycle, advance one clock, then drive slave responses.
    task automatic step();
        #1;
        if (read_data_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(read_data_valid), 32'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("rsp_data", read_data, e);
            end
        end else begin
            chk("idle_data_zero", read_data, 32'd0);
        end
        if (read_req && ready)
            exp_q.push_back(is_mapped(addr) ? resp_fn(addr) : 32'd0);
        for (int i = 0; i < NS; i++) begin
            if (s_read_req[i] && s_ready[i]) sq.push_back('{slv: i, a: addr, due: cyc + 2});
            if (s_write_req[i] && s_ready[i]) wr_acc[i]++;
        end
        @(posedge clk);
        #1;
        cyc++;
        s_read_data_valid = '0;
        for (int i = 0; i < NS; i++) s_read_data[i*32 +: 32] = $urandom;
        if (sq.size() != 0 && sq[0].due <= cyc && !hold[sq[0].slv]) begin
            int idx;
            idx = sq[0].slv;
            s_read_data_valid[idx]     = 1'b1;
            s_read_data[idx*32 +: 32]  = resp_fn(sq[0].a);
            void'(sq.pop_front());
        end
    endtask

    task automatic drain();
        int n;
        n         = 0;
        read_req  = 1'b0;
        write_req = 1'b0;
        addr      = '0;
        s_ready   = '1;
        hold      = '0;
        while ((exp_q.size() != 0 || sq.size() != 0) && n < 12) begin
            step();
            n++;
        end
        chk("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; errors = 0; cyc = 0; hold = '0;
        for (int i = 0; i < NS; i++) wr_acc[i] = 0;
        reset = 1'b1; addr = '0; write_data = '0; byte_enable = '0;
        write_req = 1'b0; read_req = 1'b0; s_ready = '1;
        s_read_data = '1; s_read_data_valid = '1;
`ifdef MEM_MAPPER_DECODE_ERROR_EN
        decode_error_clear = 1'b0;
`endif

        vecs[0] = '{32'h1000_0000, 1, 0, 32'hA5A5_0001, 4'hF, 4'hF,    1, 4'b0001, 4'b0000, 0};
        vecs[1] = '{32'h4000_0010, 1, 0, 32'h1234_5678, 4'h3, 4'hF,    1, 4'b1000, 4'b0000, 3};
        vecs[2] = '{32'h2000_0000, 1, 0, 32'h0000_00FF, 4'h1, 4'b1101, 0, 4'b0010, 4'b0000, 1};
        vecs[3] = '{32'h0000_0000, 1, 0, 32'hCAFE_0000, 4'hF, 4'b0000, 1, 4'b0000, 4'b0000, 4};
        vecs[4] = '{32'h5000_0000, 1, 0, 32'h1111_1111, 4'hF, 4'hF,    1, 4'b0000, 4'b0000, 4};
        vecs[5] = '{32'h3000_0000, 0, 1, 32'h0,         4'h0, 4'hF,    1, 4'b0000, 4'b0100, 2};
        vecs[6] = '{32'h4FFF_FFFC, 0, 1, 32'h0,         4'h0, 4'b0111, 0, 4'b0000, 4'b1000, 3};
        vecs[7] = '{32'h2000_0008, 1, 1, 32'hBEEF_0008, 4'hC, 4'hF,    1, 4'b0010, 4'b0010, 1};
        vecs[8] = '{32'h1000_0000, 0, 0, 32'h0,         4'h0, 4'b1110, 0, 4'b0000, 4'b0000, 0};
        vecs[9] = '{32'hF000_0000, 0, 1, 32'h0,         4'h0, 4'b0000, 1, 4'b0000, 4'b0000, 4};

        // Reset state, with all slave strobes forced high.
        #2;
        chk("reset_valid", 32'(read_data_valid), 32'd0);
        chk("reset_data", read_data, 32'd0);
        chk("reset_ready", 32'(ready), 32'd1);
        step();
        step();
        reset = 1'b0;

        // Table-driven decode vectors.
        for (int v = 0; v < 10; v++) begin
            addr = vecs[v].a; write_req = vecs[v].wr; read_req = vecs[v].rd;
            write_data = vecs[v].wd; byte_enable = vecs[v].be; s_ready = vecs[v].sr;
            #2;
            chk("vec_ready", 32'(ready), 32'(vecs[v].e_ready));
            chk("vec_s_write_req", 32'(s_write_req), 32'(vecs[v].e_swr));
            chk("vec_s_read_req", 32'(s_read_req), 32'(vecs[v].e_srd));
            for (int i = 0; i < NS; i++) begin
                chk("vec_s_addr", s_addr[i*32 +: 32], vecs[v].a);
                chk("vec_s_wdata", s_write_data[i*32 +: 32], (i == vecs[v].e_tgt) ? vecs[v].wd : 32'd0);
                chk("vec_s_be", 32'(s_byte_enable[i*4 +: 4]), (i == vecs[v].e_tgt) ? 32'(vecs[v].be) : 32'd0);
            end
            step();
            drain();
        end

        // Single read from slave 0 with two-cycle latency.
        addr = 32'h1000_0004; read_req = 1'b1;
        #2 chk("single_ready", 32'(ready), 32'd1);
        step();
        read_req = 1'b0; addr = '0;
        #2 chk("single_wait", 32'(read_data_valid), 32'd0);
        step();
        #2 chk("single_valid", 32'(read_data_valid), 32'd1);
        chk("single_data", read_data, 32'hDEAD_BEEF);
        step();
        #2 chk("single_one_cycle", 32'(read_data_valid), 32'd0);
        addr = 32'h3000_0000; read_req = 1'b1;
        #1 chk("single_count_zero", 32'(ready), 32'd1);
        step();
        drain();

        // Four outstanding reads to slave 1, fifth stalls until a response.
        hold[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            addr = 32'h2000_0000 + 32'(k * 4); read_req = 1'b1;
            #2 chk("b2b_ready", 32'(ready), 32'd1);
            step();
        end
        addr = 32'h2000_0010;
        #2 chk("full_stall", 32'(ready), 32'd0);
        chk("full_no_issue", 32'(s_read_req[1]), 32'd0);
        step();
        #2 chk("full_stall2", 32'(ready), 32'd0);
        step();
        hold[1] = 1'b0;
        #2 chk("full_stall3", 32'(ready), 32'd0);
        step();
        #2 chk("full_rsp_valid", 32'(read_data_valid), 32'd1);
        chk("full_no_bypass", 32'(ready), 32'd0);
        step();
        #2 chk("fifth_accept", 32'(ready), 32'd1);
        chk("fifth_issue", 32'(s_read_req[1]), 32'd1);
        step();
        drain();

        // Switching slaves waits for the previous slave to drain.
        hold[0] = 1'b1;
        addr = 32'h1000_0008; read_req = 1'b1;
        #2 chk("switch_first", 32'(ready), 32'd1);
        step();
        addr = 32'h3000_0000;
        s_read_data_valid[2] = 1'b1;
        #2 chk("switch_stall", 32'(ready), 32'd0);
        chk("switch_no_issue", 32'(s_read_req[2]), 32'd0);
        chk("foreign_valid_ignored", 32'(read_data_valid), 32'd0);
        step();
        hold[0] = 1'b0;
        #2 chk("switch_stall2", 32'(ready), 32'd0);
        step();
        #2 chk("switch_rsp", 32'(read_data_valid), 32'd1);
        chk("switch_no_bypass", 32'(ready), 32'd0);
        step();
        #2 chk("switch_issue_ready", 32'(ready), 32'd1);
        chk("switch_issue", 32'(s_read_req[2]), 32'd1);
        step();
        drain();

        // Posted write held off by slave 1 for three cycles.
        for (int i = 0; i < NS; i++) wr_acc[i] = 0;
        addr = 32'h2000_0000; write_data = 32'h0000_00FF; byte_enable = 4'b0001;
        write_req = 1'b1; s_ready = 4'b1101;
        for (int k = 0; k < 3; k++) begin
            #2 chk("wr_stall", 32'(ready), 32'd0);
            chk("wr_held", 32'(s_write_req[1]), 32'd1);
            chk("wr_be", 32'(s_byte_enable[7:4]), 32'h1);
            chk("wr_data", s_write_data[63:32], 32'h0000_00FF);
            step();
        end
        s_ready = '1;
        #2 chk("wr_accept", 32'(ready), 32'd1);
        step();
        write_req = 1'b0;
        step();
        chk("wr_once", 32'(wr_acc[1]), 32'd1);
        chk("wr_others", 32'(wr_acc[0] + wr_acc[2] + wr_acc[3]), 32'd0);

        // Unmapped read returns zero next cycle.
`ifdef MEM_MAPPER_DECODE_ERROR_EN
        decode_error_clear = 1'b1;
        step();
        decode_error_clear = 1'b0;
        #2 chk("derr_cleared", 32'(decode_error), 32'd0);
        chk("derr_addr_cleared", decode_error_addr, 32'd0);
`endif
        addr = 32'hF000_0000; read_req = 1'b1;
        #2 chk("unm_ready", 32'(ready), 32'd1);
        step();
        read_req = 1'b0; addr = '0;
        #2 chk("unm_valid", 32'(read_data_valid), 32'd1);
        chk("unm_data", read_data, 32'd0);
`ifdef MEM_MAPPER_DECODE_ERROR_EN
        chk("derr_set", 32'(decode_error), 32'd1);
        chk("derr_addr", decode_error_addr, 32'hF000_0000);
        addr = 32'hE000_0000; write_req = 1'b1; decode_error_clear = 1'b1;
        step();
        write_req = 1'b0; decode_error_clear = 1'b0; addr = '0;
        #2 chk("derr_clear_wins", 32'(decode_error), 32'd0);
`endif
        step();
        drain();

        // Reset with two reads in flight; late responses must be dropped.
        hold[3] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            addr = 32'h4000_0000 + 32'(k * 4); read_req = 1'b1;
            #2 chk("rst_issue", 32'(ready), 32'd1);
            step();
        end
        read_req = 1'b0; addr = '0;
        reset = 1'b1;
        #2 chk("rst_valid_low", 32'(read_data_valid), 32'd0);
        step();
        exp_q.delete();
        reset = 1'b0; hold[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #2 chk("late_rsp_dropped", 32'(read_data_valid), 32'd0);
            step();
        end
        addr = 32'h1000_0000; read_req = 1'b1;
        #2 chk("post_reset_count_zero", 32'(ready), 32'd1);
        step();
        drain();

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
